intdiv_qconv: RTL and testbench
===============================

// Module: intdiv_qconv
// PURPOSE
//  Quotient conversion and final-correction stage of the SD2 integer divider.
//  - Accepts one SD2 quotient digit per handshake from the iteration array, MSB first.
//  - Converts the digits on the fly into two's-complement Q and QM = Q-1.
//  - Takes padj/seladj from the sign-adjust block and registers the corrected quotient.
// PARAMETERS
//  N   8   quotient width in bits = number of SD2 digits per division (N >= 2)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   begin new division; sampled only in IDLE
//  qd_valid   in   1   qd carries a valid digit
//  qd_ready   out  1   stage accepts a digit; high only in CONV
//  qd         in   2   SD2 digit: 2'b01=+1, 2'b11=-1, 2'b00 and 2'b10 = 0
//  adj_valid  in   1   padj/seladj valid
//  adj_ready  out  1   stage accepts adjust; high only in WAIT_ADJ
//  padj       in   1   correction direction: 1 = +1, 0 = -1 (used only when seladj=0)
//  seladj     in   1   1 = no correction, 0 = apply correction
//  q_out      out  N   final two's-complement quotient, registered
//  q_valid    out  1   q_out valid; held until q_ready
//  q_ready    in   1   consumer accepts q_out
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset, async on rst_n low: state=IDLE; Q=0, QM=all ones, digit count=0.
//   Outputs: q_out=0, q_valid=0, busy=0, qd_ready=0, adj_ready=0.
//  State machine: IDLE -> CONV -> WAIT_ADJ -> CORR -> DONE -> IDLE.
//  IDLE: when start=1, load Q=0, QM={N{1'b1}}, count=0; next state is CONV.
//   qd_valid and adj_valid are ignored in IDLE.
//  CONV: a digit transfers on a cycle with qd_valid & qd_ready. Update per digit d:
//   d=+1: Q<={Q[N-2:0],1}, QM<={Q[N-2:0],0}
//   d= 0: Q<={Q[N-2:0],0}, QM<={QM[N-2:0],1}
//   d=-1: Q<={QM[N-2:0],1}, QM<={QM[N-2:0],0}
//   Both encodings of zero behave identically.
//   Each transfer increments count, which is $clog2(N+1) bits wide.
//   On the Nth transfer, go to WAIT_ADJ in the next cycle.
//   Cycles with qd_valid=0 are stalls; nothing changes.
//   adj_valid in CONV is ignored and not stored.
//  WAIT_ADJ: on adj_valid, capture padj and seladj, then go to CORR.
//   qd_valid is ignored.
//  CORR: single cycle. Selects and registers q_out:
//   seladj=1           -> q_out <= Q
//   seladj=0, padj=0   -> q_out <= QM (Q-1)
//   seladj=0, padj=1   -> q_out <= Q+1, wraps modulo 2^N (e.g. 0111+1 = 1000 for N=4)
//   q_valid <= 1; next state is DONE.
//  DONE: q_out and q_valid hold stable while q_ready=0.
//   q_valid=1 & q_ready=1: q_valid <= 0, go to IDLE. q_out keeps its last value.
//  Latency: from accepting adjust to q_valid is 2 cycles (CORR, then DONE).
//   Minimum start-to-q_valid is N+3 cycles.
//  start outside IDLE is ignored, including in the same cycle as the DONE->IDLE
//   transfer; the next division needs start in IDLE.
//  Reset asserted mid-operation aborts immediately to the reset state.
//   Partial Q/QM are discarded.
// TESTING  (N=4)
//  1 digits +1,0,-1,+1 (value 7), seladj=1 -> q_out=4'b0111; internal QM=4'b0110.
//  2 digits -1,+1,+1,0 (value -2), seladj=0 padj=0 -> q_out=4'b1101 (-3).
//  3 digits as in 1, seladj=0 padj=1 -> q_out=4'b1000 (wrap); q_valid exactly 2 cycles after adj accepted.
//  4 digits sent with 1-3 cycle qd_valid gaps; adj_valid pulsed during CONV.
//   -> pulse ignored; result equals scenario 1; adj_ready rises only after the 4th digit.
//  5 rst_n low after 2 digits -> all outputs 0 and state IDLE at once.
//   New start, then digits +1,+1,+1,+1, seladj=1 -> q_out=4'b1111.
//  6 q_ready low 5 cycles in DONE -> q_out/q_valid stable; start pulsed meanwhile is ignored.
//   q_ready=1 -> q_valid=0 next cycle, busy=0.

Source files
------------

// File: rtl/intdiv_qconv.sv
// Quotient conversion and final-correction stage of the SD2 integer divider.
// Builds Q and QM = Q-1 from MSB-first SD2 digits, then applies the sign-adjust correction.
module intdiv_qconv #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         qd_valid,
  output logic         qd_ready,
  input  logic [1:0]   qd,
  input  logic         adj_valid,
  output logic         adj_ready,
  input  logic         padj,
  input  logic         seladj,
  output logic [N-1:0] q_out,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         busy
);

  // state    | meaning
  // IDLE     | waiting for start
  // CONV     | accepting N quotient digits
  // WAIT_ADJ | waiting for padj/seladj
  // CORR     | selecting and registering the corrected quotient
  // DONE     | holding q_out/q_valid until q_ready
  typedef enum logic [2:0] {IDLE, CONV, WAIT_ADJ, CORR, DONE} state_t;

  localparam int CW = $clog2(N + 1);

  state_t        state, state_nxt;
  logic [N-1:0]  q, qm;
  logic [CW-1:0] cnt;
  logic          padj_r, seladj_r;
  logic          dig_xfer, adj_xfer;

  assign dig_xfer = (state == CONV) && qd_valid;
  assign adj_xfer = (state == WAIT_ADJ) && adj_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    qd_ready  = 1'b0;
    adj_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CONV;
      end
      CONV: begin
        qd_ready = 1'b1;
        if (qd_valid && (cnt == CW'(N - 1))) state_nxt = WAIT_ADJ;
      end
      WAIT_ADJ: begin
        adj_ready = 1'b1;
        if (adj_valid) state_nxt = CORR;
      end
      CORR: state_nxt = DONE;
      DONE: if (q_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // On-the-fly conversion: each digit shifts in from whichever of Q/QM keeps both exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      qm       <= '1;
      cnt      <= '0;
      padj_r   <= 1'b0;
      seladj_r <= 1'b1;
      q_out    <= '0;
      q_valid  <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        q   <= '0;
        qm  <= '1;
        cnt <= '0;
      end
      if (dig_xfer) begin
        case (qd)
          2'b01: begin
            q  <= {q[N-2:0], 1'b1};
            qm <= {q[N-2:0], 1'b0};
          end
          2'b11: begin
            q  <= {qm[N-2:0], 1'b1};
            qm <= {qm[N-2:0], 1'b0};
          end
          default: begin
            q  <= {q[N-2:0], 1'b0};
            qm <= {qm[N-2:0], 1'b1};
          end
        endcase
        cnt <= cnt + CW'(1);
      end
      if (adj_xfer) begin
        padj_r   <= padj;
        seladj_r <= seladj;
      end
      if (state == CORR) begin
        if (seladj_r)    q_out <= q;
        else if (padj_r) q_out <= q + N'(1);
        else             q_out <= qm;
        q_valid <= 1'b1;
      end
      if ((state == DONE) && q_ready) q_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_intdiv_qconv.sv
// Directed testbench for intdiv_qconv with N=4 and hand-computed quotients.
module tb_intdiv_qconv;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         qd_valid = 1'b0;
  logic         qd_ready;
  logic [1:0]   qd = 2'b00;
  logic         adj_valid = 1'b0;
  logic         adj_ready;
  logic         padj = 1'b0;
  logic         seladj = 1'b0;
  logic [N-1:0] q_out;
  logic         q_valid;
  logic         q_ready = 1'b0;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;

  localparam logic [1:0] P1 = 2'b01, M1 = 2'b11, Z0 = 2'b00, Z1 = 2'b10;

  intdiv_qconv #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .qd_valid(qd_valid), .qd_ready(qd_ready),
    .qd(qd), .adj_valid(adj_valid), .adj_ready(adj_ready), .padj(padj), .seladj(seladj),
    .q_out(q_out), .q_valid(q_valid), .q_ready(q_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_qd_ready", qd_ready, 1);
  endtask

  task automatic send(input logic [1:0] d, input int gap);
    int k;
    qd_valid = 1'b0;
    repeat (gap) step();
    qd = d;
    qd_valid = 1'b1;
    for (k = 0; k < 20 && !qd_ready; k++) step();
    if (!qd_ready) chk("qd_ready_timeout", qd_ready, 1);
    step();
    qd_valid = 1'b0;
  endtask

  // Hands over the adjust and checks the CORR cycle, then the DONE cycle.
  task automatic send_adj(input logic s, input logic p, input logic [N-1:0] exp_q);
    int k;
    seladj = s;
    padj = p;
    adj_valid = 1'b1;
    for (k = 0; k < 20 && !adj_ready; k++) step();
    if (!adj_ready) chk("adj_ready_timeout", adj_ready, 1);
    step();
    adj_valid = 1'b0;
    chk("corr_q_valid_low", q_valid, 0);
    step();
    chk("done_q_valid", q_valid, 1);
    chk("done_q_out", q_out, exp_q);
  endtask

  task automatic release_q();
    q_ready = 1'b1;
    step();
    q_ready = 1'b0;
    chk("release_q_valid", q_valid, 0);
    chk("release_busy", busy, 0);
  endtask

  initial begin
    #12;
    chk("rst_q_out", q_out, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_qd_ready", qd_ready, 0);
    chk("rst_adj_ready", adj_ready, 0);
    rst_n = 1'b1;
    step();

    // Inputs other than start are ignored in IDLE
    qd_valid = 1'b1;
    adj_valid = 1'b1;
    step();
    qd_valid = 1'b0;
    adj_valid = 1'b0;
    chk("idle_ignore_busy", busy, 0);

    // 1: +1,0,-1,+1 = 7, no correction, back-to-back digits
    t0 = cyc;
    do_start();
    send(P1, 0); send(Z0, 0); send(M1, 0); send(P1, 0);
    send_adj(1'b1, 1'b0, 4'b0111);
    chk("s1_latency", cyc - t0, N + 3);
    release_q();

    // Same digits, padj=0 exposes QM
    do_start();
    send(P1, 0); send(Z1, 0); send(M1, 0); send(P1, 0);
    send_adj(1'b0, 1'b0, 4'b0110);
    release_q();

    // 2: -1,+1,+1,0 = -2, correction -1
    do_start();
    send(M1, 0); send(P1, 0); send(P1, 0); send(Z0, 0);
    send_adj(1'b0, 1'b0, 4'b1101);
    release_q();

    // 3: value 7, correction +1 wraps to 1000
    do_start();
    send(P1, 0); send(Z0, 0); send(M1, 0); send(P1, 0);
    send_adj(1'b0, 1'b1, 4'b1000);
    release_q();

    // 4: gapped digits with a stray adjust pulse in CONV
    do_start();
    send(P1, 1); send(Z1, 3);
    adj_valid = 1'b1; seladj = 1'b0; padj = 1'b1;
    step();
    adj_valid = 1'b0;
    send(M1, 2);
    chk("s4_adj_ready_early", adj_ready, 0);
    send(P1, 1);
    chk("s4_adj_ready_after", adj_ready, 1);
    chk("s4_qd_ready_after", qd_ready, 0);
    repeat (2) step();
    chk("s4_wait_q_valid", q_valid, 0);
    send_adj(1'b1, 1'b0, 4'b0111);
    release_q();

    // 5: reset mid-conversion, then a fresh division
    do_start();
    send(P1, 0); send(M1, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_qd_ready", qd_ready, 0);
    chk("s5_rst_q_out", q_out, 0);
    chk("s5_rst_q_valid", q_valid, 0);
    rst_n = 1'b1;
    step();
    do_start();
    send(P1, 0); send(P1, 0); send(P1, 0); send(P1, 0);
    send_adj(1'b1, 1'b0, 4'b1111);

    // 6: back-pressure in DONE, start ignored there and on the release cycle
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      chk("s6_hold_q_valid", q_valid, 1);
      chk("s6_hold_q_out", q_out, 4'b1111);
      chk("s6_hold_busy", busy, 1);
    end
    start = 1'b1;
    release_q();
    start = 1'b0;
    step();
    chk("s6_idle_after", busy, 0);
    chk("s6_q_out_kept", q_out, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
